// File: rtl/dp_tcdm_responder_pkg.sv
// Shared definitions for the banked TCDM responder.
//   TCDM_DEAD_WORD : read data returned for out-of-range accesses
//   LFSR_TAPS      : tap mask of the 16-bit Fibonacci throttle LFSR (taps 16,14,13,11)
//   tcdm_req_t     : one port's request payload
//   lfsr_step      : one shift of the throttle LFSR
package dp_tcdm_responder_pkg;

    localparam logic [31:0] TCDM_DEAD_WORD = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dp_tcdm_responder_bank.sv
// One word-wide memory bank of the TCDM responder.
// Ports:
//   clk, rst_n, clear : clock, async active-low reset, sync pointer clear
//   req    : per-port in-range requests that decode to this bank
//   permit : per-port "not stalled and not throttled"
//   wen, be, wdata, row : per-port request fields (wen=1 read, 0 write)
//   gnt    : one-hot grant of this bank (at most one port per cycle)
//   rdata  : registered read data of the last granted read
module dp_tcdm_responder_bank #(
    parameter int N_PORT     = 4,
    parameter int BANK_WORDS = 1024,
    parameter int ROW_W      = $clog2(BANK_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [N_PORT-1:0]             req,
    input  logic [N_PORT-1:0]             permit,
    input  logic [N_PORT-1:0]             wen,
    input  logic [N_PORT-1:0][3:0]        be,
    input  logic [N_PORT-1:0][31:0]       wdata,
    input  logic [N_PORT-1:0][ROW_W-1:0]  row,
    output logic [N_PORT-1:0]             gnt,
    output logic [31:0]                   rdata
);

    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [31:0]      mem [BANK_WORDS];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] arb_idx;
    logic             found;
    logic             granted;
    int               arb_cand;
    int               nxt;

    // Round-robin search starting at the pointer. The winner is chosen among
    // requesters regardless of throttling; a denied winner blocks the bank for
    // this cycle and keeps the pointer, so it is retried first next time.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        arb_cand = 0;
        arb_idx  = '0;
        nxt      = 0;
        for (int k = 0; k < N_PORT; k++) begin
            arb_cand = int'(ptr_q) + k;
            if (arb_cand >= N_PORT) arb_cand = arb_cand - N_PORT;
            arb_idx = PTR_W'(arb_cand);
            if (!found && req[arb_idx]) begin
                found = 1'b1;
                win   = arb_idx;
            end
        end
        granted = found && permit[win];
        gnt     = granted ? (N_PORT'(1) << win) : '0;
        ptr_d   = ptr_q;
        if (granted) begin
            nxt = int'(win) + 1;
            if (nxt >= N_PORT) nxt = 0;
            ptr_d = PTR_W'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr_q <= '0;
        else if (clear) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

    // Storage is deliberately not reset so it survives a reset pulse.
    always_ff @(posedge clk) begin
        if (granted && !wen[win]) begin
            for (int i = 0; i < 4; i++) begin
                if (be[win][i]) mem[row[win]][8*i +: 8] <= wdata[win][8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rdata <= '0;
        else if (granted && wen[win])   rdata <= mem[row[win]];
    end

endmodule

// File: rtl/dp_tcdm_responder.sv
// Banked TCDM memory responder for the dot-product accelerator streamer.
// Word-interleaved banks, per-bank round-robin arbitration, 1-cycle response.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   clear_i            : sync clear of err_o and all round-robin pointers
//   stall_i            : force all grants low this cycle
//   rand_stall_en_i    : enable LFSR-based grant denial
//   err_o              : sticky out-of-range access flag
//   tcdm_req/add/wen/be/data : per-port request (wen=1 read, 0 write)
//   tcdm_gnt           : per-port combinational grant
//   tcdm_r_valid/r_data: per-port response, one cycle after each grant
module dp_tcdm_responder
    import dp_tcdm_responder_pkg::*;
#(
    parameter int          N_SLAVE_PORT = 4,
    parameter int          NB_BANKS     = 4,
    parameter int          BANK_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           stall_i,
    input  logic                           rand_stall_en_i,
    output logic                           err_o,
    input  logic [N_SLAVE_PORT-1:0]        tcdm_req,
    output logic [N_SLAVE_PORT-1:0]        tcdm_gnt,
    input  logic [N_SLAVE_PORT-1:0][31:0]  tcdm_add,
    input  logic [N_SLAVE_PORT-1:0]        tcdm_wen,
    input  logic [N_SLAVE_PORT-1:0][3:0]   tcdm_be,
    input  logic [N_SLAVE_PORT-1:0][31:0]  tcdm_data,
    output logic [N_SLAVE_PORT-1:0][31:0]  tcdm_r_data,
    output logic [N_SLAVE_PORT-1:0]        tcdm_r_valid
);

    localparam int BANK_BITS  = $clog2(NB_BANKS);
    localparam int BANK_SEL_W = (NB_BANKS > 1) ? BANK_BITS : 1;
    localparam int ROW_W      = $clog2(BANK_WORDS);

    tcdm_req_t [N_SLAVE_PORT-1:0]                  port_req;
    logic      [N_SLAVE_PORT-1:0][29:0]            word;
    logic      [N_SLAVE_PORT-1:0][29:0]            row_full;
    logic      [N_SLAVE_PORT-1:0][ROW_W-1:0]       row;
    logic      [N_SLAVE_PORT-1:0][BANK_SEL_W-1:0]  bank_sel;
    logic      [N_SLAVE_PORT-1:0]                  in_range;
    logic      [N_SLAVE_PORT-1:0]                  port_wen;
    logic      [N_SLAVE_PORT-1:0][3:0]             port_be;
    logic      [N_SLAVE_PORT-1:0][31:0]            port_wdata;
    logic      [N_SLAVE_PORT-1:0]                  permit;
    logic      [N_SLAVE_PORT-1:0]                  oor_gnt;
    logic      [NB_BANKS-1:0][N_SLAVE_PORT-1:0]    bank_req;
    logic      [NB_BANKS-1:0][N_SLAVE_PORT-1:0]    bank_gnt;
    logic      [NB_BANKS-1:0][31:0]                bank_rdata;
    logic      [15:0]                              lfsr_q;

    logic      [N_SLAVE_PORT-1:0]                  r_valid_q;
    logic      [N_SLAVE_PORT-1:0]                  resp_read;
    logic      [N_SLAVE_PORT-1:0]                  resp_oor;
    logic      [N_SLAVE_PORT-1:0][BANK_SEL_W-1:0]  resp_bank;

    // Address decode. Addresses below BASE_ADDR wrap to huge word numbers, so
    // the explicit lower-bound test is what rejects them.
    always_comb begin
        for (int p = 0; p < N_SLAVE_PORT; p++) begin
            port_req[p]   = '{add: tcdm_add[p], wen: tcdm_wen[p], be: tcdm_be[p], data: tcdm_data[p]};
            word[p]       = 30'((port_req[p].add - BASE_ADDR) >> 2);
            row_full[p]   = word[p] >> BANK_BITS;
            row[p]        = row_full[p][ROW_W-1:0];
            bank_sel[p]   = BANK_SEL_W'(word[p] & 30'(NB_BANKS - 1));
            in_range[p]   = (port_req[p].add >= BASE_ADDR) && (row_full[p] < 30'(BANK_WORDS));
            port_wen[p]   = port_req[p].wen;
            port_be[p]    = port_req[p].be;
            port_wdata[p] = port_req[p].data;
            permit[p]     = !stall_i && !(rand_stall_en_i && lfsr_q[p]);
            oor_gnt[p]    = tcdm_req[p] && !in_range[p] && permit[p];
        end
    end

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int p = 0; p < N_SLAVE_PORT; p++) begin
                bank_req[b][p] = tcdm_req[p] && in_range[p] && (bank_sel[p] == BANK_SEL_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        dp_tcdm_responder_bank #(
            .N_PORT     (N_SLAVE_PORT),
            .BANK_WORDS (BANK_WORDS),
            .ROW_W      (ROW_W)
        ) u_bank (
            .clk    (clk_i),
            .rst_n  (rst_ni),
            .clear  (clear_i),
            .req    (bank_req[b]),
            .permit (permit),
            .wen    (port_wen),
            .be     (port_be),
            .wdata  (port_wdata),
            .row    (row),
            .gnt    (bank_gnt[b]),
            .rdata  (bank_rdata[b])
        );
    end

    // A port is granted by at most one path: its own bank or the
    // out-of-range path, so OR-ing the sources is safe.
    always_comb begin
        tcdm_gnt = oor_gnt;
        for (int b = 0; b < NB_BANKS; b++) tcdm_gnt = tcdm_gnt | bank_gnt[b];
    end

    // Throttle LFSR free-runs, independent of stall_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_step(lfsr_q);
    end

    // Remember which source answers each port next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
            resp_read <= '0;
            resp_oor  <= '0;
            resp_bank <= '0;
        end else begin
            r_valid_q <= tcdm_gnt;
            resp_read <= tcdm_gnt & port_wen;
            resp_oor  <= ~in_range;
            resp_bank <= bank_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       err_o <= 1'b0;
        else if (clear_i)  err_o <= 1'b0;
        else if (|oor_gnt) err_o <= 1'b1;
    end

    // Write responses and idle cycles return zero data.
    always_comb begin
        for (int p = 0; p < N_SLAVE_PORT; p++) begin
            tcdm_r_data[p] = '0;
            if (resp_read[p]) tcdm_r_data[p] = resp_oor[p] ? TCDM_DEAD_WORD : bank_rdata[resp_bank[p]];
        end
    end

    assign tcdm_r_valid = r_valid_q;

endmodule

// File: tb/tb_dp_tcdm_responder.sv
// Directed self-checking bench for dp_tcdm_responder (default parameters).
module tb_dp_tcdm_responder;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               clear_i;
    logic               stall_i;
    logic               rand_stall_en_i;
    logic               err_o;
    logic [N-1:0]       tcdm_req;
    logic [N-1:0]       tcdm_gnt;
    logic [N-1:0][31:0] tcdm_add;
    logic [N-1:0]       tcdm_wen;
    logic [N-1:0][3:0]  tcdm_be;
    logic [N-1:0][31:0] tcdm_data;
    logic [N-1:0][31:0] tcdm_r_data;
    logic [N-1:0]       tcdm_r_valid;

    int testsRun    = 0;
    int testsFailed = 0;

    int          idx       [N];
    logic        pend      [N];
    logic [31:0] expData   [N];
    int          respCount [N];
    logic [N-1:0] g;
    int          cyc;
    bit          allDone;

    dp_tcdm_responder u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .stall_i         (stall_i),
        .rand_stall_en_i (rand_stall_en_i),
        .err_o           (err_o),
        .tcdm_req        (tcdm_req),
        .tcdm_gnt        (tcdm_gnt),
        .tcdm_add        (tcdm_add),
        .tcdm_wen        (tcdm_wen),
        .tcdm_be         (tcdm_be),
        .tcdm_data       (tcdm_data),
        .tcdm_r_data     (tcdm_r_data),
        .tcdm_r_valid    (tcdm_r_valid)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] pattern(input int p, input int i);
        return {8'(p), 8'hC3, 16'(i)};
    endfunction

    task automatic clearReqs();
        tcdm_req  = '0;
        tcdm_add  = '0;
        tcdm_wen  = '0;
        tcdm_be   = '0;
        tcdm_data = '0;
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] a, input logic w,
                                 input logic [3:0] b, input logic [31:0] d);
        tcdm_req[p]  = 1'b1;
        tcdm_add[p]  = a;
        tcdm_wen[p]  = w;
        tcdm_be[p]   = b;
        tcdm_data[p] = d;
    endtask

    // Called just after a negedge with requests driven: checks the
    // same-cycle grant, then r_valid one cycle later.
    task automatic runCycle(input logic [N-1:0] expGnt, input string tag);
        #1;
        checkOutput({tag, " gnt"}, 32'(tcdm_gnt), 32'(expGnt));
        @(posedge clk_i);
        #1;
        checkOutput({tag, " r_valid"}, 32'(tcdm_r_valid), 32'(expGnt));
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_i = 1'b0;
        stall_i = 1'b0;
        rand_stall_en_i = 1'b0;
        clearReqs();
        #12;
        checkOutput("reset r_valid", 32'(tcdm_r_valid), 32'h0);
        checkOutput("reset r_data0", tcdm_r_data[0], 32'h0);
        checkOutput("reset err", 32'(err_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Write then read back on port 0
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE, 1'b0, 4'hF, 32'h1234_5678);
        runCycle(4'b0001, "wr0");
        checkOutput("wr0 r_data", tcdm_r_data[0], 32'h0);
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE, 1'b1, 4'hF, 32'h0);
        runCycle(4'b0001, "rd0");
        checkOutput("rd0 r_data", tcdm_r_data[0], 32'h1234_5678);

        // Byte enable merge
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE + 32'h40, 1'b0, 4'hF, 32'hFFFF_FFFF);
        runCycle(4'b0001, "be full");
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE + 32'h40, 1'b0, 4'b0001, 32'h0000_00AA);
        runCycle(4'b0001, "be byte0");
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE + 32'h40, 1'b1, 4'hF, 32'h0);
        runCycle(4'b0001, "be read");
        checkOutput("be r_data", tcdm_r_data[0], 32'hFFFF_FFAA);

        // Reset pointers, then all four ports contend for bank 0
        @(negedge clk_i); clearReqs(); clear_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i); clear_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk_i); clearReqs();
            for (int p = k; p < N; p++) applyStimulus(p, BASE + 32'(16 * p), 1'b1, 4'hF, 32'h0);
            runCycle(N'(1) << k, $sformatf("rr order %0d", k));
            if (k == 0) checkOutput("rr port0 r_data", tcdm_r_data[0], 32'h1234_5678);
        end
        @(negedge clk_i); clearReqs();
        for (int p = 0; p < N; p++) applyStimulus(p, BASE + 32'(16 * p), 1'b1, 4'hF, 32'h0);
        runCycle(4'b0001, "rr wrap");

        // Distinct banks: full parallelism
        @(negedge clk_i); clearReqs();
        for (int p = 0; p < N; p++) applyStimulus(p, BASE + 32'(4 * p), 1'b0, 4'hF, 32'hA000_0000 + 32'(p));
        runCycle(4'b1111, "par wr");
        for (int p = 0; p < N; p++) checkOutput($sformatf("par wr r_data%0d", p), tcdm_r_data[p], 32'h0);
        @(negedge clk_i); clearReqs();
        for (int p = 0; p < N; p++) applyStimulus(p, BASE + 32'(4 * p), 1'b1, 4'hF, 32'h0);
        runCycle(4'b1111, "par rd");
        for (int p = 0; p < N; p++) checkOutput($sformatf("par rd r_data%0d", p), tcdm_r_data[p], 32'hA000_0000 + 32'(p));

        // Out-of-range below base and just past the top, and the last valid word
        checkOutput("err before oor", 32'(err_o), 32'h0);
        @(negedge clk_i); clearReqs(); applyStimulus(0, BASE - 32'h4, 1'b1, 4'hF, 32'h0);
        runCycle(4'b0001, "oor low");
        checkOutput("oor low r_data", tcdm_r_data[0], 32'hDEAD_BEEF);
        checkOutput("oor low err", 32'(err_o), 32'h1);
        @(negedge clk_i); clearReqs(); applyStimulus(1, BASE + 32'h4000, 1'b0, 4'hF, 32'h55);
        runCycle(4'b0010, "oor high wr");
        checkOutput("oor high r_data", tcdm_r_data[1], 32'h0);
        @(negedge clk_i); clearReqs(); applyStimulus(2, BASE + 32'h3FFC, 1'b0, 4'hF, 32'hCAFE_F00D);
        runCycle(4'b0100, "top wr");
        @(negedge clk_i); clearReqs(); applyStimulus(2, BASE + 32'h3FFC, 1'b1, 4'hF, 32'h0);
        runCycle(4'b0100, "top rd");
        checkOutput("top r_data", tcdm_r_data[2], 32'hCAFE_F00D);
        checkOutput("err sticky", 32'(err_o), 32'h1);
        @(negedge clk_i); clearReqs(); clear_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("err cleared", 32'(err_o), 32'h0);
        @(negedge clk_i); clear_i = 1'b0;

        // Throttled streams: 256 writes then 256 reads per port, stall pulse mid-way
        rand_stall_en_i = 1'b1;
        for (int p = 0; p < N; p++) begin
            idx[p] = 0;
            respCount[p] = 0;
        end
        cyc = 0;
        allDone = 1'b0;
        while (!allDone && cyc < 6000) begin
            @(negedge clk_i);
            clearReqs();
            stall_i = (cyc >= 100 && cyc < 105);
            for (int p = 0; p < N; p++) begin
                if (idx[p] < 512) begin
                    if (idx[p] < 256)
                        applyStimulus(p, BASE + 32'(4 * (256 * p + idx[p])), 1'b0, 4'hF, pattern(p, idx[p]));
                    else
                        applyStimulus(p, BASE + 32'(4 * (256 * p + idx[p] - 256)), 1'b1, 4'hF, 32'h0);
                end
            end
            #1;
            g = tcdm_gnt;
            if (stall_i) checkOutput("stall gnt", 32'(g), 32'h0);
            for (int p = 0; p < N; p++) begin
                pend[p] = g[p];
                if (g[p]) begin
                    expData[p] = (idx[p] >= 256) ? pattern(p, idx[p] - 256) : 32'h0;
                    idx[p]++;
                end
            end
            @(posedge clk_i);
            #1;
            allDone = 1'b1;
            for (int p = 0; p < N; p++) begin
                checkOutput($sformatf("stream r_valid%0d", p), 32'(tcdm_r_valid[p]), 32'(pend[p]));
                if (pend[p]) checkOutput($sformatf("stream r_data%0d", p), tcdm_r_data[p], expData[p]);
                if (tcdm_r_valid[p]) respCount[p]++;
                if (idx[p] < 512) allDone = 1'b0;
            end
            cyc++;
        end
        stall_i = 1'b0;
        rand_stall_en_i = 1'b0;
        checkOutput("stream complete", 32'(allDone), 32'h1);
        for (int p = 0; p < N; p++) checkOutput($sformatf("stream count%0d", p), 32'(respCount[p]), 32'd512);

        // Reset while responses are pending; memory must survive
        @(negedge clk_i); clearReqs();
        for (int p = 0; p < N; p++) applyStimulus(p, BASE + 32'(4 * p), 1'b1, 4'hF, 32'h0);
        runCycle(4'b1111, "pre-reset");
        rst_ni = 1'b0;
        #1;
        checkOutput("mid reset r_valid", 32'(tcdm_r_valid), 32'h0);
        checkOutput("mid reset r_data0", tcdm_r_data[0], 32'h0);
        @(negedge clk_i); rst_ni = 1'b1; clearReqs();
        @(negedge clk_i); applyStimulus(0, BASE, 1'b1, 4'hF, 32'h0);
        runCycle(4'b0001, "post-reset rd");
        checkOutput("post-reset r_data", tcdm_r_data[0], pattern(0, 0));
        @(negedge clk_i); clearReqs();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
